// File: rtl/alu_issue.sv
// Decode-and-issue front end for the registered 5-bit-op ALU: decode, issue, capture, hand off.
// Define ALU_CLX_EN to decode SPECIAL2 clo/clz; otherwise opcode 0x1C is illegal.
`timescale 1ns/1ps

module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_dest,
    output logic        out_we,
    output logic        out_is_branch,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rt, rd;
    logic [15:0] imm;

    assign opcode = instr[31:26];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    // rs index and shamt are not needed: rs arrives as data, shifts are illegal.
    logic unused_fields;
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    logic [4:0]  dec_op;
    logic [31:0] dec_a, dec_b;
    logic [4:0]  dec_dest;
    logic        dec_branch, dec_legal, dec_we;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        dec_op     = 5'd0;
        dec_a      = rs_data;
        dec_b      = rt_data;
        dec_dest   = 5'd0;
        dec_branch = 1'b0;
        dec_legal  = 1'b0;
        case (opcode)
            6'h00: begin
                dec_dest  = rd;
                dec_legal = 1'b1;
                case (funct)
                    6'h20:                      dec_op = 5'd0;
                    6'h21:                      dec_op = 5'd1;
                    6'h22, 6'h23:               dec_op = 5'd3;
                    6'h24, 6'h25, 6'h26, 6'h27: dec_op = {2'b00, funct[2:0]};
                    6'h2A:                      dec_op = 5'd10;
                    6'h2B:                      dec_op = 5'd11;
                    default:                    dec_legal = 1'b0;
                endcase
            end
            6'h01: begin
                dec_b      = 32'd0;
                dec_branch = 1'b1;
                if (rt == 5'd0) begin
                    dec_op    = 5'd17;
                    dec_legal = 1'b1;
                end else if (rt == 5'd1) begin
                    dec_op    = 5'd25;
                    dec_legal = 1'b1;
                end
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                dec_op     = {3'b101, opcode[1:0]};
                dec_branch = 1'b1;
                dec_legal  = 1'b1;
                if (opcode[1]) dec_b = 32'd0;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dec_op    = {1'b0, opcode[3:0]};
                dec_dest  = rt;
                dec_legal = 1'b1;
                if (opcode == 6'h0F) begin
                    dec_a = {16'd0, imm};
                    dec_b = 32'd0;
                end else if (opcode[3:2] == 2'b11) begin
                    dec_b = {16'd0, imm};
                end else begin
                    dec_b = {{16{imm[15]}}, imm};
                end
            end
`ifdef ALU_CLX_EN
            6'h1C: begin
                dec_b    = 32'd0;
                dec_dest = rd;
                if (funct == 6'h21) begin
                    dec_op    = 5'd28;
                    dec_legal = 1'b1;
                end else if (funct == 6'h20) begin
                    dec_op    = 5'd29;
                    dec_legal = 1'b1;
                end
            end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_we = dec_legal && !dec_branch && (dec_dest != 5'd0);

    logic        accept;
    logic [4:0]  alu_op_q;
    logic [31:0] alu_a_q, alu_b_q, out_data_q;
    logic [4:0]  out_dest_q;
    logic        out_we_q, out_branch_q, illegal_q;

    assign accept = (state_q == S_IDLE) && in_valid;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = dec_legal ? S_ISSUE : S_DONE;
            end
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            alu_op_q     <= 5'd0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            out_data_q   <= 32'd0;
            out_dest_q   <= 5'd0;
            out_we_q     <= 1'b0;
            out_branch_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_data_q   <= 32'd0;
                out_dest_q   <= dec_legal ? dec_dest : 5'd0;
                out_we_q     <= dec_we;
                out_branch_q <= dec_legal && dec_branch;
                illegal_q    <= !dec_legal;
                // Illegal instructions never reach the ALU, so its inputs keep their last value.
                if (dec_legal) begin
                    alu_op_q <= dec_op;
                    alu_a_q  <= dec_a;
                    alu_b_q  <= dec_b;
                end
            end
            if (state_q == S_CAPTURE) out_data_q <= alu_result;
        end
    end

    assign alu_op        = alu_op_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign out_data      = out_data_q;
    assign out_dest      = out_dest_q;
    assign out_we        = out_we_q;
    assign out_is_branch = out_branch_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a registered ALU model on the issue port.
`timescale 1ns/1ps

module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr, rs_data, rt_data;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_dest;
    logic        out_we, out_is_branch, illegal;

    int vectors = 0;
    int miscompares = 0;
    int lat;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dest(out_dest), .out_we(out_we), .out_is_branch(out_is_branch),
        .illegal(illegal)
    );

    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        bit          hit;
        r = 32'd0;
        hit = 1'b0;
        case (op)
            5'd0, 5'd1, 5'd8, 5'd9: r = a + b;
            5'd3:        r = a - b;
            5'd4, 5'd12: r = a & b;
            5'd5, 5'd13: r = a | b;
            5'd6, 5'd14: r = a ^ b;
            5'd7:        r = ~(a | b);
            5'd10:       r = {31'd0, $signed(a) < $signed(b)};
            5'd11:       r = {31'd0, a < b};
            5'd15:       r = a << 16;
            5'd20:       r = {31'd0, a == b};
            5'd21:       r = {31'd0, a != b};
            5'd22:       r = {31'd0, $signed(a) <= 0};
            5'd23:       r = {31'd0, $signed(a) > 0};
            5'd17:       r = {31'd0, $signed(a) < 0};
            5'd25:       r = {31'd0, $signed(a) >= 0};
            5'd28: for (int i = 31; i >= 0; i--) if (!hit) begin if (a[i]) r = r + 1; else hit = 1'b1; end
            5'd29: for (int i = 31; i >= 0; i--) if (!hit) begin if (!a[i]) r = r + 1; else hit = 1'b1; end
            default:     r = 32'd0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) alu_result <= alu_model(alu_op, alu_a, alu_b);

    task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        instr = i; rs_data = rs; rt_data = rt; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        vectors++; if ({alu_op, alu_a, alu_b} !== 69'd0) begin miscompares++; $display("FAIL rst_alu got %h/%h/%h exp 0", alu_op, alu_a, alu_b); end
        vectors++; if ({out_data, out_dest, out_we, out_is_branch, illegal} !== 40'd0) begin
            miscompares++; $display("FAIL rst_outs got %h %h %b%b%b exp 0", out_data, out_dest, out_we, out_is_branch, illegal); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        send(32'h00221820, 32'd5, 32'd7);
        vectors++; if (alu_op !== 5'd0) begin miscompares++; $display("FAIL add_op got %0d exp 0", alu_op); end
        vectors++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin miscompares++; $display("FAIL add_ab got %h/%h exp 5/7", alu_a, alu_b); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL add_busy got %b exp 0", in_ready); end
        wait_valid(lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL add_latency got %0d exp 3", lat); end
        vectors++; if (out_data !== 32'd12) begin miscompares++; $display("FAIL add_data got %h exp 0000000c", out_data); end
        vectors++; if (out_dest !== 5'd3 || out_we !== 1'b1) begin miscompares++; $display("FAIL add_dest got %0d we %b exp 3 we 1", out_dest, out_we); end
        vectors++; if (out_is_branch !== 1'b0 || illegal !== 1'b0) begin miscompares++; $display("FAIL add_flags got br %b ill %b exp 0 0", out_is_branch, illegal); end
        release_out();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL add_release got v %b r %b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_sub();
        send(32'h00221822, 32'd5, 32'd7);
        vectors++; if (alu_op !== 5'd3) begin miscompares++; $display("FAIL sub_op got %0d exp 3", alu_op); end
        wait_valid(lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL sub_latency got %0d exp 3", lat); end
        vectors++; if (out_data !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL sub_data got %h exp fffffffe", out_data); end
        release_out();
    endtask

    task automatic test_immediates();
        send(32'h3422FFFF, 32'd0, 32'hDEADBEEF);
        vectors++; if (alu_op !== 5'd13) begin miscompares++; $display("FAIL ori_op got %0d exp 13", alu_op); end
        vectors++; if (alu_b !== 32'h0000FFFF) begin miscompares++; $display("FAIL ori_b got %h exp 0000ffff", alu_b); end
        wait_valid(lat);
        vectors++; if (out_data !== 32'h0000FFFF) begin miscompares++; $display("FAIL ori_data got %h exp 0000ffff", out_data); end
        vectors++; if (out_dest !== 5'd2 || out_we !== 1'b1) begin miscompares++; $display("FAIL ori_dest got %0d we %b exp 2 we 1", out_dest, out_we); end
        release_out();
        send(32'h2022FFFF, 32'd5, 32'hDEADBEEF);
        vectors++; if (alu_op !== 5'd8 || alu_b !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL addi_opb got %0d/%h exp 8/ffffffff", alu_op, alu_b); end
        wait_valid(lat);
        vectors++; if (out_data !== 32'd4) begin miscompares++; $display("FAIL addi_data got %h exp 00000004", out_data); end
        release_out();
        send(32'h3C041234, 32'hAAAA5555, 32'hDEADBEEF);
        vectors++; if (alu_op !== 5'd15) begin miscompares++; $display("FAIL lui_op got %0d exp 15", alu_op); end
        vectors++; if (alu_a !== 32'h00001234 || alu_b !== 32'd0) begin miscompares++; $display("FAIL lui_ab got %h/%h exp 00001234/0", alu_a, alu_b); end
        wait_valid(lat);
        vectors++; if (out_data !== 32'h12340000) begin miscompares++; $display("FAIL lui_data got %h exp 12340000", out_data); end
        vectors++; if (out_dest !== 5'd4 || out_we !== 1'b1) begin miscompares++; $display("FAIL lui_dest got %0d we %b exp 4 we 1", out_dest, out_we); end
        release_out();
    endtask

    task automatic test_branch();
        send(32'h10220000, 32'd9, 32'd9);
        vectors++; if (alu_op !== 5'd20) begin miscompares++; $display("FAIL beq_op got %0d exp 20", alu_op); end
        wait_valid(lat);
        vectors++; if (out_data !== 32'd1) begin miscompares++; $display("FAIL beq_data got %h exp 1", out_data); end
        vectors++; if (out_is_branch !== 1'b1 || out_we !== 1'b0) begin miscompares++; $display("FAIL beq_flags got br %b we %b exp 1 0", out_is_branch, out_we); end
        release_out();
        send(32'h04200000, 32'hFFFFFFFF, 32'h12345678);
        vectors++; if (alu_op !== 5'd17 || alu_b !== 32'd0) begin miscompares++; $display("FAIL bltz_opb got %0d/%h exp 17/0", alu_op, alu_b); end
        wait_valid(lat);
        vectors++; if (out_data !== 32'd1 || out_is_branch !== 1'b1 || out_we !== 1'b0) begin
            miscompares++; $display("FAIL bltz_out got %h br %b we %b exp 1 1 0", out_data, out_is_branch, out_we); end
        release_out();
        send(32'h00220020, 32'd5, 32'd7);
        wait_valid(lat);
        vectors++; if (out_data !== 32'd12 || out_we !== 1'b0) begin miscompares++; $display("FAIL rd0_we got %h we %b exp 0000000c we 0", out_data, out_we); end
        release_out();
    endtask

    task automatic test_backpressure();
        send(32'h00221820, 32'd5, 32'd7);
        wait_valid(lat);
        @(negedge clk);
        instr = 32'h3C041234; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hs[%0d] got v %b r %b exp 1 0", i, out_valid, in_ready); end
            vectors++; if (out_data !== 32'd12 || out_dest !== 5'd3) begin miscompares++; $display("FAIL bp_hold[%0d] got %h/%0d exp c/3", i, out_data, out_dest); end
            vectors++; if (alu_op !== 5'd0) begin miscompares++; $display("FAIL bp_alu[%0d] got %0d exp 0", i, alu_op); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got v %b r %b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_illegal();
        send(32'h3C041234, 32'd0, 32'd0);
        wait_valid(lat);
        release_out();
        send(32'hFC000000, 32'd5, 32'd7);
        wait_valid(lat);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL ill_latency got %0d exp 1", lat); end
        vectors++; if (illegal !== 1'b1 || out_data !== 32'd0 || out_we !== 1'b0) begin
            miscompares++; $display("FAIL ill_out got ill %b data %h we %b exp 1 0 0", illegal, out_data, out_we); end
        vectors++; if (alu_op !== 5'd15 || alu_a !== 32'h00001234) begin miscompares++; $display("FAIL ill_alu_hold got %0d/%h exp 15/00001234", alu_op, alu_a); end
        release_out();
        send(32'h00021080, 32'd5, 32'd7);
        wait_valid(lat);
        vectors++; if (lat !== 1 || illegal !== 1'b1) begin miscompares++; $display("FAIL sll_ill got lat %0d ill %b exp 1 1", lat, illegal); end
        release_out();
    endtask

    task automatic test_clx();
        send(32'h70201821, 32'hF0000000, 32'd0);
        wait_valid(lat);
`ifdef ALU_CLX_EN
        vectors++; if (lat !== 3 || out_data !== 32'd4) begin miscompares++; $display("FAIL clo_data got lat %0d data %h exp 3 4", lat, out_data); end
        vectors++; if (out_dest !== 5'd3 || illegal !== 1'b0) begin miscompares++; $display("FAIL clo_dest got %0d ill %b exp 3 0", out_dest, illegal); end
`else
        vectors++; if (lat !== 1 || illegal !== 1'b1) begin miscompares++; $display("FAIL clo_ill got lat %0d ill %b exp 1 1", lat, illegal); end
        vectors++; if (out_data !== 32'd0 || out_we !== 1'b0) begin miscompares++; $display("FAIL clo_out got %h we %b exp 0 0", out_data, out_we); end
`endif
        release_out();
    endtask

    task automatic test_reset_mid_op();
        send(32'h00221820, 32'd5, 32'd7);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mrst_hs got v %b r %b exp 0 1", out_valid, in_ready); end
        vectors++; if (alu_op !== 5'd0 || alu_a !== 32'd0 || out_dest !== 5'd0) begin
            miscompares++; $display("FAIL mrst_outs got %0d/%h/%0d exp 0", alu_op, alu_a, out_dest); end
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h00221822, 32'd5, 32'd7);
        wait_valid(lat);
        vectors++; if (lat !== 3 || out_data !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL mrst_next got lat %0d data %h exp 3 fffffffe", lat, out_data); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_immediates();
        test_branch();
        test_backpressure();
        test_illegal();
        test_clx();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
